// File: rtl/interval_timer_pkg.sv
// Register map, field positions and shared types for the multi-channel interval timer.
// The optional per-channel prescaler is enabled by defining INTERVAL_TIMER_PRESCALE_EN.
package interval_timer_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PERIOD   = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AR    = 1;
  localparam int CTRL_IE    = 2;
  localparam int STATUS_TO  = 0;
  localparam int PRESCALE_W = 16;

  // Field order matches CTRL_EN/CTRL_AR/CTRL_IE bit positions.
  typedef struct packed {
    logic ie;
    logic ar;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    logic [31:0] w;
    w          = 32'd0;
    w[CTRL_EN] = c.en;
    w[CTRL_AR] = c.ar;
    w[CTRL_IE] = c.ie;
    return w;
  endfunction

endpackage

// File: rtl/interval_timer_channel.sv
// One timer channel: control/period/count/status registers, optional prescaler
// (INTERVAL_TIMER_PRESCALE_EN), timeout generation and a read port for the top-level mux.
module interval_timer_channel
  import interval_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_ctrl,
  input  logic        wr_period,
  input  logic        wr_count,
  input  logic        wr_status,
  input  logic        wr_prescale,
  input  logic [31:0] wdata,
  input  logic [2:0]  rd_reg,
  output logic [31:0] rd_word,
  output logic        irq_req
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);

  ctrl_t            ctrl_q, ctrl_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             to_q, to_d;
  logic             tick_s;
  logic             timeout_s;
  logic             unused_wdata;

`ifdef INTERVAL_TIMER_PRESCALE_EN
  localparam logic [PRESCALE_W-1:0] PSC_ZERO = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] PSC_ONE  = PRESCALE_W'(1'b1);

  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] psc_cnt_q, psc_cnt_d;

  assign unused_wdata = ^wdata;
  // >= keeps the divider sane when PRESCALE is lowered below the running count.
  assign tick_s = ctrl_q.en && (psc_cnt_q >= prescale_q);

  // Prescale register and divider; restarts on any CTRL or COUNT write.
  always_comb begin
    prescale_d = prescale_q;
    psc_cnt_d  = psc_cnt_q;
    if (wr_prescale) begin
      prescale_d = wdata[PRESCALE_W-1:0];
    end else begin
      prescale_d = prescale_q;
    end
    if (wr_ctrl || wr_count) begin
      psc_cnt_d = PSC_ZERO;
    end else if (ctrl_q.en) begin
      psc_cnt_d = (psc_cnt_q >= prescale_q) ? PSC_ZERO : (psc_cnt_q + PSC_ONE);
    end else begin
      psc_cnt_d = psc_cnt_q;
    end
  end

  // Prescaler state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_q <= PSC_ZERO;
      psc_cnt_q  <= PSC_ZERO;
    end else begin
      prescale_q <= prescale_d;
      psc_cnt_q  <= psc_cnt_d;
    end
  end
`else
  assign unused_wdata = ^{wdata, wr_prescale};
  assign tick_s       = ctrl_q.en;
`endif

  // A COUNT write in the tick cycle suppresses both the decrement and the timeout.
  assign timeout_s = tick_s && !wr_count && (count_q == CNT_ZERO);
  assign irq_req   = to_q && ctrl_q.ie;

  // Next-state for control, period, count and sticky timeout flag.
  always_comb begin
    ctrl_d   = ctrl_q;
    period_d = period_q;
    count_d  = count_q;
    to_d     = to_q;

    if (wr_ctrl) begin
      ctrl_d = ctrl_t'(wdata[CTRL_IE:CTRL_EN]);
    end else if (timeout_s && !ctrl_q.ar) begin
      ctrl_d.en = 1'b0;
    end else begin
      ctrl_d = ctrl_q;
    end

    if (wr_period) begin
      period_d = wdata[WIDTH-1:0];
    end else begin
      period_d = period_q;
    end

    if (wr_count) begin
      count_d = wdata[WIDTH-1:0];
    end else if (!tick_s) begin
      count_d = count_q;
    end else if (count_q != CNT_ZERO) begin
      count_d = count_q - CNT_ONE;
    end else if (ctrl_q.ar) begin
      count_d = period_q;
    end else begin
      count_d = count_q;
    end

    // A new timeout beats a simultaneous write-1-to-clear.
    to_d = (to_q && !(wr_status && wdata[STATUS_TO])) || timeout_s;
  end

  // Channel register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= 3'b000;
      period_q <= CNT_ZERO;
      count_q  <= CNT_ZERO;
      to_q     <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      period_q <= period_d;
      count_q  <= count_d;
      to_q     <= to_d;
    end
  end

  // Register read view, zero-extended to the bus width.
  always_comb begin
    rd_word = 32'd0;
    case (rd_reg)
      REG_CTRL:   rd_word = ctrl_word(ctrl_q);
      REG_PERIOD: rd_word[WIDTH-1:0] = period_q;
      REG_COUNT:  rd_word[WIDTH-1:0] = count_q;
      REG_STATUS: rd_word[STATUS_TO] = to_q;
`ifdef INTERVAL_TIMER_PRESCALE_EN
      REG_PRESCALE: rd_word[PRESCALE_W-1:0] = prescale_q;
`endif
      default:    rd_word = 32'd0;
    endcase
  end

endmodule

// File: rtl/interval_timer.sv
// Multi-channel programmable interval timer on a memory-mapped slave bus with one irq line.
// Define INTERVAL_TIMER_PRESCALE_EN to add the per-channel 16-bit prescaler (register 4).
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            irq,
  input  logic            s_cs_n,
  input  logic [CH_W+2:0] s_address,
  input  logic            s_read,
  output logic [31:0]     s_readdata,
  input  logic            s_write,
  input  logic [31:0]     s_writedata
);

  logic                rd_s;
  logic                wr_s;
  logic [CH_W-1:0]     ch_sel_s;
  logic [2:0]          reg_sel_s;
  logic [31:0]         rd_word_s [CHANNELS];
  logic [CHANNELS-1:0] irq_req_s;
  logic [31:0]         readdata_q, readdata_d;
  logic                irq_q, irq_d;

  assign rd_s      = !s_cs_n && s_read;
  assign wr_s      = !s_cs_n && s_write;
  assign ch_sel_s  = s_address[CH_W+2:3];
  assign reg_sel_s = s_address[2:0];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [CH_W:0] IDX = (CH_W+1)'(i);
    logic ch_wr_s;

    assign ch_wr_s = wr_s && ({1'b0, ch_sel_s} == IDX);

    interval_timer_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .clk         (clk),
      .reset_n     (reset_n),
      .wr_ctrl     (ch_wr_s && (reg_sel_s == REG_CTRL)),
      .wr_period   (ch_wr_s && (reg_sel_s == REG_PERIOD)),
      .wr_count    (ch_wr_s && (reg_sel_s == REG_COUNT)),
      .wr_status   (ch_wr_s && (reg_sel_s == REG_STATUS)),
      .wr_prescale (ch_wr_s && (reg_sel_s == REG_PRESCALE)),
      .wdata       (s_writedata),
      .rd_reg      (reg_sel_s),
      .rd_word     (rd_word_s[i]),
      .irq_req     (irq_req_s[i])
    );
  end

  // Read mux; channel indices with no instance fall through to zero.
  always_comb begin
    readdata_d = readdata_q;
    if (rd_s) begin
      readdata_d = 32'd0;
      for (int i = 0; i < CHANNELS; i++) begin
        if ({1'b0, ch_sel_s} == (CH_W+1)'(i)) begin
          readdata_d = rd_word_s[i];
        end else begin
          readdata_d = readdata_d;
        end
      end
    end else begin
      readdata_d = readdata_q;
    end
  end

  assign irq_d = |irq_req_s;

  // Registered bus read data and interrupt output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign s_readdata = readdata_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_interval_timer.sv
// Randomised bench for interval_timer against a cycle-level reference model of the register rules.
module tb_interval_timer;

  localparam int W   = 16;
  localparam int NCH = 3;
  localparam int CW  = 2;
  localparam logic [31:0] CNT_MASK = 32'h0000_ffff;

  logic            clk;
  logic            reset_n;
  logic            irq;
  logic            s_cs_n;
  logic [CW+2:0]   s_address;
  logic            s_read;
  logic [31:0]     s_readdata;
  logic            s_write;
  logic [31:0]     s_writedata;

  interval_timer #(.WIDTH(W), .CHANNELS(NCH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .irq         (irq),
    .s_cs_n      (s_cs_n),
    .s_address   (s_address),
    .s_read      (s_read),
    .s_readdata  (s_readdata),
    .s_write     (s_write),
    .s_writedata (s_writedata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, one entry per channel.
  bit          m_en [NCH];
  bit          m_ar [NCH];
  bit          m_ie [NCH];
  bit          m_to [NCH];
  logic [31:0] m_per[NCH];
  logic [31:0] m_cnt[NCH];
  logic [31:0] m_psc[NCH];
  logic [31:0] m_pcnt[NCH];
  logic [31:0] exp_rd;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_en[c] = 0; m_ar[c] = 0; m_ie[c] = 0; m_to[c] = 0;
      m_per[c] = 0; m_cnt[c] = 0; m_psc[c] = 0; m_pcnt[c] = 0;
    end
    exp_rd = 32'd0;
  endtask

  function automatic logic [31:0] model_read(input int ch, input int r);
    if (ch >= NCH) return 32'd0;
    case (r)
      0: return {29'd0, m_ie[ch], m_ar[ch], m_en[ch]};
      1: return m_per[ch];
      2: return m_cnt[ch];
      3: return {31'd0, m_to[ch]};
`ifdef INTERVAL_TIMER_PRESCALE_EN
      4: return m_psc[ch];
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit model_irq();
    bit v;
    v = 0;
    for (int c = 0; c < NCH; c++) v = v | (m_to[c] & m_ie[c]);
    return v;
  endfunction

  function automatic bit model_tick(input int c);
`ifdef INTERVAL_TIMER_PRESCALE_EN
    return m_en[c] && (m_pcnt[c] >= m_psc[c]);
`else
    return m_en[c];
`endif
  endfunction

  // Advance the model by one clock with an optional accepted write.
  task automatic model_step(input bit wr, input int ch, input int r, input logic [31:0] d);
    for (int c = 0; c < NCH; c++) begin
      bit w, tick, timeout;
      w       = wr && (ch == c);
      tick    = model_tick(c);
      timeout = tick && !(w && r == 2) && (m_cnt[c] == 0);
`ifdef INTERVAL_TIMER_PRESCALE_EN
      if (w && (r == 0 || r == 2)) m_pcnt[c] = 0;
      else if (m_en[c]) m_pcnt[c] = (m_pcnt[c] >= m_psc[c]) ? 0 : m_pcnt[c] + 1;
      if (w && r == 4) m_psc[c] = d & 32'h0000_ffff;
`endif
      if (w && r == 2) m_cnt[c] = d & CNT_MASK;
      else if (tick) m_cnt[c] = (m_cnt[c] != 0) ? m_cnt[c] - 1 : (m_ar[c] ? m_per[c] : 32'd0);
      if (w && r == 0) begin
        m_en[c] = d[0]; m_ar[c] = d[1]; m_ie[c] = d[2];
      end else if (timeout && !m_ar[c]) begin
        m_en[c] = 0;
      end
      if (w && r == 1) m_per[c] = d & CNT_MASK;
      if (w && r == 3 && d[0]) m_to[c] = 0;
      if (timeout) m_to[c] = 1;
    end
  endtask

  // One bus cycle; irq and readdata are checked after every edge.
  task automatic cyc(input bit cs, input bit wr, input bit rd, input int ch, input int r,
                     input logic [31:0] d);
    logic [31:0] next_rd;
    bit          next_irq;
    s_cs_n      = !cs;
    s_write     = wr;
    s_read      = rd;
    s_address   = {ch[CW-1:0], r[2:0]};
    s_writedata = d;
    next_rd  = (cs && rd) ? model_read(ch, r) : exp_rd;
    next_irq = model_irq();
    @(posedge clk);
    model_step(cs && wr, ch, r, d);
    exp_rd = next_rd;
    #1;
    check_eq("irq", {31'd0, irq}, {31'd0, next_irq});
    check_eq("readdata", s_readdata, exp_rd);
    s_cs_n = 1'b1; s_write = 1'b0; s_read = 1'b0;
  endtask

  task automatic wr_reg(input int ch, input int r, input logic [31:0] d);
    cyc(1'b1, 1'b1, 1'b0, ch, r, d);
  endtask

  task automatic rd_reg(input int ch, input int r);
    cyc(1'b1, 1'b0, 1'b1, ch, r, 32'd0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 32'd0);
  endtask

  task automatic quiet_all();
    for (int c = 0; c < NCH; c++) begin
      wr_reg(c, 0, 32'd0);
      wr_reg(c, 3, 32'd1);
    end
    idle();
  endtask

  // Wait for irq, clear the channel's TO, and measure cycles to the next irq rise.
  task automatic measure_interval(input string tag, input int ch, input int exp_n);
    int n;
    n = 0;
    while (!irq && n < 60) begin idle(); n++; end
    check_eq({tag, "_rise"}, {31'd0, irq}, 32'd1);
    wr_reg(ch, 3, 32'd1);
    idle();
    check_eq({tag, "_fall"}, {31'd0, irq}, 32'd0);
    n = 2;
    while (!irq && n < 60) begin idle(); n++; end
    check_eq({tag, "_interval"}, n, exp_n);
  endtask

  initial begin
    int k, ch, r, n;
    logic [31:0] d;

    reset_n = 1'b0; s_cs_n = 1'b1; s_read = 1'b0; s_write = 1'b0;
    s_address = '0; s_writedata = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_irq", {31'd0, irq}, 32'd0);
    check_eq("reset_readdata", s_readdata, 32'd0);
    reset_n = 1'b1;

    // Auto-reload: PERIOD=4 gives a timeout every 5 ticks.
    wr_reg(0, 1, 32'd4);
    wr_reg(0, 2, 32'd4);
    wr_reg(0, 0, 32'h7);
    measure_interval("autoreload", 0, 5);

    // One-shot on ch1.
    quiet_all();
    wr_reg(1, 2, 32'd3);
    wr_reg(1, 0, 32'h5);
    repeat (6) idle();
    rd_reg(1, 0); check_eq("oneshot_ctrl", s_readdata, 32'h4);
    rd_reg(1, 2); check_eq("oneshot_count", s_readdata, 32'h0);
    rd_reg(1, 3); check_eq("oneshot_to", s_readdata, 32'h1);
    check_eq("oneshot_irq", {31'd0, irq}, 32'd1);

    // STATUS clear lands in the exact cycle of a ch0 timeout.
    quiet_all();
    wr_reg(0, 1, 32'd2);
    wr_reg(0, 2, 32'd2);
    wr_reg(0, 0, 32'h7);
    n = 0;
    while (!(model_tick(0) && m_cnt[0] == 0) && n < 20) begin idle(); n++; end
    check_eq("collision_sched", {31'd0, (n < 20)}, 32'd1);
    wr_reg(0, 3, 32'd1);
    rd_reg(0, 3); check_eq("collision_to", s_readdata, 32'h1);
    check_eq("collision_irq", {31'd0, irq}, 32'd1);

    // Masking: ch0 times out without IE, ch1 with IE.
    quiet_all();
    wr_reg(0, 1, 32'd0);
    wr_reg(0, 0, 32'h3);
    wr_reg(1, 2, 32'd2);
    wr_reg(1, 0, 32'h5);
    check_eq("mask_ch0_only", {31'd0, irq}, 32'd0);
    repeat (5) idle();
    check_eq("mask_ch1_irq", {31'd0, irq}, 32'd1);
    wr_reg(3, 1, 32'h55);
    rd_reg(3, 1); check_eq("bad_channel", s_readdata, 32'h0);
    wr_reg(0, 1, 32'hABCD_1234);
    rd_reg(0, 1); check_eq("width_trunc", s_readdata, 32'h0000_1234);

`ifdef INTERVAL_TIMER_PRESCALE_EN
    quiet_all();
    wr_reg(2, 4, 32'd2);
    wr_reg(2, 1, 32'd1);
    wr_reg(2, 2, 32'd1);
    wr_reg(2, 0, 32'h7);
    measure_interval("prescale", 2, 6);
`else
    wr_reg(0, 4, 32'h0000_0003);
    rd_reg(0, 4); check_eq("prescale_absent", s_readdata, 32'h0);
`endif

    // Randomised traffic, including strobes without chip select.
    for (int i = 0; i < 800; i++) begin
      k  = $urandom_range(0, 9);
      ch = $urandom_range(0, 3);
      r  = $urandom_range(0, 7);
      d  = $urandom;
      if ((r == 1 || r == 2) && $urandom_range(0, 7) != 0) d = $urandom_range(0, 6);
      if (r == 4) d = $urandom_range(0, 3);
      if (k < 3)       cyc(1'b1, 1'b1, 1'b0, ch, r, d);
      else if (k < 6)  cyc(1'b1, 1'b0, 1'b1, ch, r, d);
      else if (k == 6) cyc(1'b0, $urandom_range(0, 1) == 1, 1'b0, ch, r, d);
      else             idle();
    end

    // Reset in the middle of counting.
    wr_reg(0, 1, 32'd3);
    wr_reg(0, 2, 32'd3);
    wr_reg(0, 0, 32'h7);
    rd_reg(0, 1);
    repeat (6) idle();
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("midreset_irq", {31'd0, irq}, 32'd0);
    check_eq("midreset_readdata", s_readdata, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      for (int rr = 0; rr < 5; rr++) begin
        rd_reg(c, rr);
        check_eq("post_reset_reg", s_readdata, 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
